t07_mem_arbiter: RTL and testbench

- Shares the single memory port between instruction fetch and data load/store.
- Sequences each access as a request/acknowledge transaction.
- Drives the owner select that steers the memory address source.
- Sits between the CPU core (fetch unit plus load/store unit) and the memory handler. Raises `freeze` to stall the core while any access is outstanding.

---
 rtl/t07_mem_arb_pkg.sv | 14 +
 rtl/t07_mem_arb_watchdog.sv | 37 +++
 rtl/t07_mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_t07_mem_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/t07_mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory-port arbiter.
package t07_mem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StData,
    StResp
  } state_t;

  localparam logic [31:0] ERR_DATA  = 32'hBAD0_BAD0;
  localparam logic [3:0]  FETCH_SEL = 4'hF;

endpackage

// File: rtl/t07_mem_arb_watchdog.sv
// Access watchdog: counts stalled cycles of an outstanding memory access and
// flags expiry on the cycle that reaches TIMEOUT_CYC.
module t07_mem_arb_watchdog #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic active_i,
  input  logic mem_ack_i,
  output logic expired_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Idle/turnaround cycles hold the count at zero, so every access starts fresh.
  always_comb begin
    cnt_d = cnt_q;
    if (!active_i) begin
      cnt_d = '0;
    end else if (!mem_ack_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = active_i && !mem_ack_i && (cnt_q == CntW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/t07_mem_arbiter.sv
// Arbitrates the single memory port between instruction fetch and data load/store.
// Optional access watchdog enabled by defining T07_MEM_ARB_TIMEOUT_EN.
module t07_mem_arbiter
  import t07_mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_ren,
  input  logic              d_wen,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [3:0]        d_sel,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_sel,
  output logic              mem_ren,
  output logic              mem_wen,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              grant_data,
  output logic              freeze,
  output logic              timeout_err
);

  state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        sel_q;
  logic              wr_q;
  logic              is_data_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;

  logic              d_any;
  logic              busy;
  logic              timeout;
  logic              complete;
  logic [DATA_W-1:0] rdata_in;

  assign d_any    = d_ren | d_wen;
  assign busy     = (state_q == StFetch) || (state_q == StData);
  assign complete = busy && (mem_ack || timeout);

`ifdef T07_MEM_ARB_TIMEOUT_EN
  logic timeout_err_q;

  t07_mem_arb_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .active_i (busy),
    .mem_ack_i(mem_ack),
    .expired_o(timeout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_err_q <= 1'b0;
    end else if (timeout) begin
      timeout_err_q <= 1'b1;
    end
  end

  assign timeout_err = timeout_err_q;
  assign rdata_in    = timeout ? DATA_W'(ERR_DATA) : mem_rdata;
`else
  assign timeout     = 1'b0;
  assign timeout_err = 1'b0;
  assign rdata_in    = mem_rdata;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        // Data has fixed priority over fetch.
        if (d_any) begin
          state_d = StData;
        end else if (if_req) begin
          state_d = StFetch;
        end
      end
      StFetch, StData: begin
        if (complete) begin
          state_d = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      wdata_q    <= '0;
      sel_q      <= '0;
      wr_q       <= 1'b0;
      is_data_q  <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle) begin
        if (d_any) begin
          addr_q    <= d_addr;
          wdata_q   <= d_wdata;
          sel_q     <= d_sel;
          wr_q      <= d_wen;
          is_data_q <= 1'b1;
        end else if (if_req) begin
          addr_q    <= if_addr;
          wdata_q   <= '0;
          sel_q     <= FETCH_SEL;
          wr_q      <= 1'b0;
          is_data_q <= 1'b0;
        end
      end
      if (complete) begin
        if (state_q == StFetch) begin
          if_rdata_q <= rdata_in;
        end else if (!wr_q) begin
          d_rdata_q <= rdata_in;
        end
      end
    end
  end

  // Memory side is driven only from latched request fields.
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_sel    = sel_q;
  assign mem_ren    = (state_q == StFetch) || ((state_q == StData) && !wr_q);
  assign mem_wen    = (state_q == StData) && wr_q;
  assign grant_data = (state_q == StData);

  assign if_ack   = (state_q == StResp) && !is_data_q;
  assign d_ack    = (state_q == StResp) && is_data_q;
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;

  assign freeze = ((state_q == StIdle) && (if_req || d_any)) || busy;

endmodule

// File: tb/tb_t07_mem_arbiter.sv
// Self-checking bench for t07_mem_arbiter: vector table plus scoreboard and
// hand-written multi-cycle sequences (reset, priority, watchdog).
module tb_t07_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ack;
  logic          d_ren;
  logic          d_wen;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [3:0]    d_sel;
  logic [DW-1:0] d_rdata;
  logic          d_ack;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_sel;
  logic          mem_ren;
  logic          mem_wen;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic          grant_data;
  logic          freeze;
  logic          timeout_err;

  always #5 clk = ~clk;

  t07_mem_arbiter #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_rdata   (if_rdata),
    .if_ack     (if_ack),
    .d_ren      (d_ren),
    .d_wen      (d_wen),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_sel      (d_sel),
    .d_rdata    (d_rdata),
    .d_ack      (d_ack),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_sel    (mem_sel),
    .mem_ren    (mem_ren),
    .mem_wen    (mem_wen),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .grant_data (grant_data),
    .freeze     (freeze),
    .timeout_err(timeout_err)
  );

  int checks = 0;
  int errors = 0;

  // mode: 0 plain, 1 change d_addr/d_sel while waiting, 2 drop if_req mid-fetch,
  // 3 hold d_ren through the response cycle
  typedef struct {
    logic        is_data;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic [31:0] rdata;
    int          waits;
    int          mode;
  } vec_t;

  typedef struct {
    logic        is_data;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  vec_t        vecs[6];
  logic [31:0] m_if_rdata = '0;
  logic [31:0] m_d_rdata  = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    exp_t        e;
    logic        exp_wen;
    logic [3:0]  exp_sel;
    int          k;
    bit          seen;
    exp_wen = v.is_data & v.wr;
    exp_sel = v.is_data ? v.sel : 4'hF;
    @(negedge clk);
    if_req  = !v.is_data;
    d_ren   = v.is_data & v.rd;
    d_wen   = v.is_data & v.wr;
    if_addr = v.addr;
    d_addr  = v.addr;
    d_wdata = v.wdata;
    d_sel   = v.sel;
    e.is_data = v.is_data;
    if (v.is_data) begin
      if (!v.wr) m_d_rdata = v.rdata;
      e.rdata = m_d_rdata;
    end else begin
      m_if_rdata = v.rdata;
      e.rdata    = m_if_rdata;
    end
    sb.push_back(e);
    #1 chk("freeze_on_request", freeze, 1'b1);
    @(negedge clk);
    for (int w = 0; w <= v.waits; w++) begin
      chk("mem_ren", mem_ren, !exp_wen);
      chk("mem_wen", mem_wen, exp_wen);
      chk("mem_addr", mem_addr, v.addr);
      chk("mem_sel", mem_sel, exp_sel);
      chk("grant_data", grant_data, v.is_data);
      chk("freeze_busy", freeze, 1'b1);
      if (exp_wen) chk("mem_wdata", mem_wdata, v.wdata);
      if (v.mode == 1) begin
        d_addr = ~v.addr;
        d_sel  = 4'h0;
      end
      if (v.mode == 2) if_req = 1'b0;
      mem_ack   = (w == v.waits);
      mem_rdata = (w == v.waits) ? v.rdata : $urandom;
      @(negedge clk);
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
    end
    seen = 0;
    for (k = 0; k < 4; k++) begin
      if (if_ack || d_ack) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    chk("ack_latency", k, 0);
    e = sb.pop_front();
    if (seen) begin
      chk("d_ack", d_ack, e.is_data);
      chk("if_ack", if_ack, !e.is_data);
      if (e.is_data) chk("d_rdata", d_rdata, e.rdata);
      else           chk("if_rdata", if_rdata, e.rdata);
      chk("freeze_resp", freeze, 1'b0);
      chk("strobes_resp", {mem_ren, mem_wen}, 2'b00);
    end
    if (v.mode != 3) begin
      if_req = 0; d_ren = 0; d_wen = 0;
    end
    @(negedge clk);
    chk("ack_single_pulse", {if_ack, d_ack}, 2'b00);
    chk("strobes_idle", {mem_ren, mem_wen}, 2'b00);
    if (v.mode == 3) begin
      d_ren = 0;
      @(negedge clk);
      chk("no_reservice", {mem_ren, d_ack}, 2'b00);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int cnt;
    rst = 1'b1;
    if_req = 0; if_addr = '0; d_ren = 0; d_wen = 0; d_addr = '0; d_wdata = '0; d_sel = '0;
    mem_rdata = '0; mem_ack = 0;

    vecs[0] = '{1'b0, 1'b0, 1'b0, 32'h0000_0040, 32'h0, 4'h0, 32'h0051_0513, 3, 0};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 32'h3300_0004, 32'hCAFE_F00D, 4'b0011, 32'h1111_1111, 2, 1};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'hF, 32'h1234_5678, 0, 0};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 32'h0000_0200, 32'hA5A5_5A5A, 4'b1100, 32'h2222_2222, 1, 0};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 32'h0000_0044, 32'h0, 4'h0, 32'hDEAD_BEEF, 2, 2};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 32'h0000_0300, 32'h0, 4'hF, 32'h5566_7788, 1, 3};

    repeat (2) @(negedge clk);
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_d_rdata", d_rdata, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_sel", mem_sel, 4'h0);
    chk("rst_ctrl", {mem_ren, mem_wen, grant_data, if_ack, d_ack, freeze, timeout_err}, 7'b0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // mem_ack while idle is ignored
    @(negedge clk);
    mem_ack = 1; mem_rdata = 32'hFFFF_0000;
    @(negedge clk);
    mem_ack = 0;
    chk("idle_ack_ignored", {if_ack, d_ack, mem_ren}, 3'b000);
    chk("idle_ack_if_rdata", if_rdata, m_if_rdata);
    chk("idle_ack_d_rdata", d_rdata, m_d_rdata);

    // Simultaneous fetch and data read: data first, then fetch
    @(negedge clk);
    d_ren = 1; d_addr = 32'h0000_0500; d_sel = 4'hF; if_req = 1; if_addr = 32'h0000_0080;
    #1 chk("both_freeze", freeze, 1'b1);
    @(negedge clk);
    chk("both_grant_data", grant_data, 1'b1);
    chk("both_data_addr", mem_addr, 32'h0000_0500);
    chk("both_data_ren", mem_ren, 1'b1);
    mem_ack = 1; mem_rdata = 32'h1111_2222;
    @(negedge clk);
    mem_ack = 0;
    m_d_rdata = 32'h1111_2222;
    chk("both_d_ack", {d_ack, if_ack}, 2'b10);
    chk("both_d_rdata", d_rdata, m_d_rdata);
    chk("both_resp_freeze", freeze, 1'b0);
    d_ren = 0;
    @(negedge clk);
    chk("both_idle_freeze", freeze, 1'b1);
    chk("both_idle_grant", grant_data, 1'b0);
    @(negedge clk);
    chk("both_fetch_grant", grant_data, 1'b0);
    chk("both_fetch_addr", mem_addr, 32'h0000_0080);
    chk("both_fetch_sel", mem_sel, 4'hF);
    chk("both_fetch_freeze", freeze, 1'b1);
    mem_ack = 1; mem_rdata = 32'h3333_4444;
    @(negedge clk);
    mem_ack = 0;
    m_if_rdata = 32'h3333_4444;
    chk("both_if_ack", {d_ack, if_ack}, 2'b01);
    chk("both_if_rdata", if_rdata, m_if_rdata);
    if_req = 0;
    @(negedge clk);
    chk("both_done_freeze", freeze, 1'b0);

`ifdef T07_MEM_ARB_TIMEOUT_EN
    @(negedge clk);
    d_ren = 1; d_addr = 32'h0000_0600;
    @(negedge clk);
    cnt = 0;
    while (mem_ren && cnt < 20) begin
      cnt++;
      @(negedge clk);
    end
    chk("timeout_cycles", cnt, TO);
    chk("timeout_d_ack", d_ack, 1'b1);
    chk("timeout_rdata", d_rdata, 32'hBAD0_BAD0);
    chk("timeout_err_set", timeout_err, 1'b1);
    d_ren = 0;
    repeat (3) @(negedge clk);
    chk("timeout_err_sticky", timeout_err, 1'b1);
    rst = 1;
    #1 chk("timeout_err_rst", timeout_err, 1'b0);
    @(negedge clk);
    rst = 0;
    m_d_rdata = '0; m_if_rdata = '0;
`else
    @(negedge clk);
    d_ren = 1; d_addr = 32'h0000_0600;
    repeat (20) @(negedge clk);
    chk("no_timeout_still_waiting", mem_ren, 1'b1);
    chk("no_timeout_err", timeout_err, 1'b0);
    mem_ack = 1; mem_rdata = 32'h0000_0077;
    @(negedge clk);
    mem_ack = 0;
    m_d_rdata = 32'h0000_0077;
    chk("no_timeout_d_ack", d_ack, 1'b1);
    chk("no_timeout_rdata", d_rdata, m_d_rdata);
    d_ren = 0;
    @(negedge clk);
`endif

    // Reset in the middle of a write
    @(negedge clk);
    d_wen = 1; d_addr = 32'h0000_0700; d_wdata = 32'h0000_0099; d_sel = 4'hF;
    @(negedge clk);
    chk("rstmid_wen_before", mem_wen, 1'b1);
    #2 rst = 1;
    #1;
    chk("rstmid_wen_after", mem_wen, 1'b0);
    chk("rstmid_grant", grant_data, 1'b0);
    chk("rstmid_mem_addr", mem_addr, 32'h0);
    chk("rstmid_d_rdata", d_rdata, 32'h0);
    d_wen = 0;
    cnt = 0;
    if (d_ack) cnt++;
    @(negedge clk);
    if (d_ack) cnt++;
    rst = 0;
    repeat (5) begin
      @(negedge clk);
      if (d_ack || mem_wen) cnt++;
    end
    chk("rstmid_no_ack", cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
